// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and the receive shift helper
package spi_pkg;
    typedef enum logic {MSB_FIRST, LSB_FIRST} bit_order_t;
    typedef enum logic {IDLE, SHIFT} spi_rx_state_t;

    function automatic logic [7:0] shift_in(logic [7:0] sr, logic b, bit_order_t ord);
        return (ord == MSB_FIRST) ? {sr[6:0], b} : {b, sr[7:1]};
    endfunction
endpackage

// File: rtl/spi_receiver_if.sv
// spi_receiver_if: controller-side bus of the SPI receive path
interface spi_receiver_if;
    import spi_pkg::*;
    logic       receive_i;
    logic       sample_i;
    logic       spi_miso_i;
    bit_order_t bit_order_i;
    logic       read_i;
    logic       clear_overrun_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       overrun_o;
    modport master (
        output receive_i, sample_i, spi_miso_i, bit_order_i, read_i, clear_overrun_i,
        input  data_o, valid_o, busy_o, overrun_o
    );
    modport slave (
        input  receive_i, sample_i, spi_miso_i, bit_order_i, read_i, clear_overrun_i,
        output data_o, valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/edge_detector.sv
// edge_detector: single-cycle pulse on a selected edge, flagged in the edge's own cycle
module edge_detector #(
    parameter logic RISING    = 1'b1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic edge_o
);
    logic prev_q;
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) prev_q <= RESET_VAL;
        else          prev_q <= d_i;
    assign edge_o = RISING ? (d_i & ~prev_q) : (~d_i & prev_q);
endmodule

// File: rtl/spi_receiver.sv
// spi_receiver: SPI serial-to-parallel byte receiver with holding register,
// valid/read handshake and sticky overrun flag
module spi_receiver
    import spi_pkg::*;
(
    input logic         clk_i,
    input logic         rst_n_i,
    spi_receiver_if.slave bus
);
    spi_rx_state_t state_q, state_d;
    bit_order_t    order_q;
    logic [2:0]    cnt_q;
    logic [7:0]    shreg_q, data_q, shifted;
    logic          valid_q, busy_q, overrun_q, start_edge, done;

    edge_detector #(.RISING(1'b1), .RESET_VAL(1'b0)) u_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (bus.receive_i),
        .edge_o  (start_edge)
    );

    assign shifted = shift_in(shreg_q, bus.spi_miso_i, order_q);

    always_comb begin
        done    = (state_q == SHIFT) && bus.sample_i && (cnt_q == 3'd7);
        state_d = (state_q == IDLE) ? (start_edge ? SHIFT : IDLE) : (done ? IDLE : SHIFT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            order_q   <= MSB_FIRST;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            busy_q <= (state_d == SHIFT);
            if (state_q == IDLE && start_edge) begin
                cnt_q   <= '0;
                shreg_q <= '0;
                order_q <= bus.bit_order_i;
            end else if (state_q == SHIFT && bus.sample_i) begin
                cnt_q   <= cnt_q + 3'd1;
                shreg_q <= shifted;
            end
            // overwrite of an unread byte sets overrun; set beats clear
            if (done && valid_q && !bus.read_i) overrun_q <= 1'b1;
            else if (bus.clear_overrun_i)       overrun_q <= 1'b0;
            if (done) begin
                data_q  <= shifted;
                valid_q <= 1'b1;
            end else if (bus.read_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;
endmodule
